// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Feature macro: UART_TX_FIFO_ALMOST_FULL_EN (enables almost_full compare).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_LOAD,
    TXF_BUSY
  } txf_state_t;

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO for the TX path: storage, pointers, occupancy and status flags.
// Feature macro: UART_TX_FIFO_ALMOST_FULL_EN drives almost_full from count.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              almost_full
);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("uart_sync_fifo: AF_THRESH must be in 1..DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              push;

  // a pop frees a slot in the same edge, so a full FIFO still accepts
  assign push = wr_en && (!full || pop);

  always_comb begin
    cnt_nxt = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  logic af_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (cnt_nxt >= CW'(AF_THRESH));
    end
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte buffer plus load sequencer feeding the UART shift register.
// Feature macro: UART_TX_FIFO_ALMOST_FULL_EN (almost_full flag).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = 16,
  parameter int LOAD_HOLD = 16,
  parameter int AF_THRESH = 12,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int HW       = $clog2(LOAD_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              almost_full,
  input  logic              tx_done,
  output logic              load,
  output logic [DATA_W-1:0] data_out
);

  if (LOAD_HOLD < 1) begin : g_bad_hold
    $error("uart_tx_fifo: LOAD_HOLD must be >= 1");
  end

  txf_state_t        state;
  logic [HW-1:0]     hold_cnt;
  logic              tx_done_q;
  logic              done_rise;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  assign pop       = (state == TXF_IDLE) && !empty;
  assign done_rise = tx_done && !tx_done_q;

  uart_sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .pop         (pop),
    .rd_data     (rd_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .almost_full (almost_full)
  );

  // done edges outside BUSY are dropped, but the edge register keeps tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= TXF_IDLE;
      hold_cnt  <= '0;
      load      <= 1'b0;
      data_out  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      unique case (state)
        TXF_IDLE: begin
          if (pop) begin
            data_out <= rd_data;
            load     <= 1'b1;
            hold_cnt <= '0;
            state    <= TXF_LOAD;
          end
        end
        TXF_LOAD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(LOAD_HOLD - 1)) begin
            load  <= 1'b0;
            state <= TXF_BUSY;
          end
        end
        TXF_BUSY: begin
          if (done_rise) begin
            state <= TXF_IDLE;
          end
        end
        default: begin
          load  <= 1'b0;
          state <= TXF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a queue-based reference model.
// Honours UART_TX_FIFO_ALMOST_FULL_EN for the almost_full expectation.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int LOAD_HOLD = 16;
  localparam int AF_THRESH = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       almost_full;
  logic       load;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];

  uart_tx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .almost_full (almost_full),
    .tx_done     (tx_done),
    .load        (load),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    wr_en   = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    q.delete();
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_load(input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    while (load !== lvl && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (load !== lvl) begin
      errors++;
      $display("FAIL %s load got %b want %b within %0d clk", nm, load, lvl, lim);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    wr_en = 1'b1;
    tick();
    tick();
    wr_en = 1'b0;
    checks++;
    if ({empty, full, count} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_flags got e%b f%b c%0d want e1 f0 c0", empty, full, count);
    end
    checks++;
    if ({load, data_out, overflow, almost_full} !== 11'd0) begin
      errors++;
      $display("FAIL reset_out got l%b d%h o%b af%b want 0", load, data_out, overflow, almost_full);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int hi;
    do_reset();
    push(8'hA5);
    checks++;
    if (load !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL single_edge1 got l%b c%0d want l0 c1", load, count);
    end
    tick();
    checks++;
    if ({load, data_out, count, empty} !== {1'b1, 8'hA5, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_edge2 got l%b d%h c%0d e%b want l1 dA5 c0 e1", load, data_out, count, empty);
    end
    hi = 1;
    while (load === 1'b1 && hi < 40) begin
      tick();
      if (load === 1'b1) hi++;
    end
    checks++;
    if (hi != LOAD_HOLD) begin
      errors++;
      $display("FAIL single_hold got %0d want %0d", hi, LOAD_HOLD);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    push(8'h3C);
    tick();
    checks++;
    if (load !== 1'b1 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL single_next got l%b d%h want l1 d3c", load, data_out);
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i));
    exp = q.pop_front();
    checks++;
    if (data_out !== exp || count !== 5'(q.size())) begin
      errors++;
      $display("FAIL fill_state got d%h c%0d want d%h c%0d", data_out, count, exp, q.size());
    end
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_flags got f%b o%b want f1 o0", full, overflow);
    end
    wait_load(1'b0, LOAD_HOLD + 2, "fill_busy");
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    push(8'h11);
    exp = q.pop_front();
    checks++;
    if ({data_out, count, full, overflow} !== {exp, 5'(q.size()), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fill_pushpop got d%h c%0d f%b o%b want d%h c%0d f1 o0",
               data_out, count, full, overflow, exp, q.size());
    end
    wr_en   = 1'b1;
    wr_data = 8'h12;
    tick();
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'(q.size())) begin
      errors++;
      $display("FAIL fill_overflow got o%b c%0d want o1 c%0d", overflow, count, q.size());
    end
  endtask

  task automatic test_order_wrap();
    do_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int n;
          repeat ($urandom_range(0, 3)) tick();
          n = 0;
          while (full === 1'b1 && n < 500) begin
            tick();
            n++;
          end
          push(8'($urandom));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          logic [7:0] exp;
          int hi;
          wait_load(1'b1, 200, "order_load");
          exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
          checks++;
          if (data_out !== exp) begin
            errors++;
            $display("FAIL order_byte%0d got %h want %h", k, data_out, exp);
          end
          hi = 1;
          while (load === 1'b1 && hi < 40) begin
            tick();
            if (load === 1'b1) hi++;
          end
          checks++;
          if (hi != LOAD_HOLD) begin
            errors++;
            $display("FAIL order_hold%0d got %0d want %0d", k, hi, LOAD_HOLD);
          end
          repeat ($urandom_range(0, 3)) tick();
          tx_done = 1'b1;
          tick();
          tx_done = 1'b0;
        end
      end
    join
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL order_end got o%b e%b want o0 e1", overflow, empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1;
    do_reset();
    push(8'($urandom));
    b1 = 8'($urandom);
    push(b1);
    wait_load(1'b0, LOAD_HOLD + 2, "b2b_busy");
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (load !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got l%b want l0", load);
    end
    tick();
    checks++;
    if (load !== 1'b1 || data_out !== b1) begin
      errors++;
      $display("FAIL b2b_load got l%b d%h want l1 d%h", load, data_out, b1);
    end
  endtask

  task automatic test_done_level();
    logic [7:0] b1;
    do_reset();
    push(8'($urandom));
    b1 = 8'($urandom);
    push(b1);
    tx_done = 1'b1;
    wait_load(1'b0, LOAD_HOLD + 2, "lvl_busy");
    repeat (30) tick();
    checks++;
    if (load !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL lvl_held got l%b c%0d want l0 c1", load, count);
    end
    tx_done = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tick();
    tx_done = 1'b0;
    checks++;
    if (load !== 1'b1 || data_out !== b1) begin
      errors++;
      $display("FAIL lvl_rise got l%b d%h want l1 d%h", load, data_out, b1);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int i = 0; i < 6; i++) push(8'($urandom));
    checks++;
    if (load !== 1'b1 || count !== 5'd5) begin
      errors++;
      $display("FAIL midrst_pre got l%b c%0d want l1 c5", load, count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({load, count, empty, data_out} !== {1'b0, 5'd0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL midrst got l%b c%0d e%b d%h want l0 c0 e1 d00", load, count, empty, data_out);
    end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (load !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after got l%b e%b want l0 e1", load, empty);
    end
  endtask

  task automatic test_almost_full();
    logic exp;
    do_reset();
    push(8'($urandom));
    tick();
    for (int i = 0; i < AF_THRESH - 1; i++) push(8'($urandom));
    checks++;
    if (almost_full !== 1'b0 || count !== 5'(AF_THRESH - 1)) begin
      errors++;
      $display("FAIL af_below got af%b c%0d want af0 c%0d", almost_full, count, AF_THRESH - 1);
    end
    push(8'($urandom));
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    checks++;
    if (almost_full !== exp || count !== 5'(AF_THRESH)) begin
      errors++;
      $display("FAIL af_at got af%b c%0d want af%b c%0d", almost_full, count, exp, AF_THRESH);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_order_wrap();
    test_back_to_back();
    test_done_level();
    test_reset_mid_load();
    test_almost_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
